// File: rtl/clock_divider_n.sv
// clock_divider_n
//   Programmable integer clock divider. Produces a registered, glitch-free
//   divided clock and a one-cycle tick on every divided rising edge. A newly
//   loaded divisor is held as "pending" and only takes over at a period
//   boundary (wrap), so no partial or truncated period is ever produced.
//
// Ports
//   clock_i       system clock, rising edge
//   reset_i       asynchronous reset, active low
//   enable_i      1 = divider runs, 0 = counting/output frozen, tick forced 0
//   load_i        strobe: capture div_value_i (clamped to >= 2) as pending
//   div_value_i   requested divisor N (2 .. 2^WIDTH-1)
//   clock_out_o   divided clock: high for ceil(N/2) cycles, low for the rest
//   tick_o        one-cycle pulse on the first high cycle of each period
//   pending_o     a loaded divisor is waiting for the next wrap
module clock_divider_n #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_value_i,
    output logic             clock_out_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_DIV - 1);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_div_q, active_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pending_q, pending_d;
    logic             clock_out_q, clock_out_d;
    logic             tick_q, tick_d;

    logic             wrap;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] next_div;

    // Counter resets to N-1 so the first enabled edge is a wrap and the
    // divided clock starts with its high phase and a tick.
    assign wrap     = (cnt_q == active_div_q - WIDTH'(1));
    assign cnt_inc  = cnt_q + WIDTH'(1);
    // ceil(N/2) without widening: N>>1 plus the dropped LSB.
    assign half     = (active_div_q >> 1) + {{(WIDTH-1){1'b0}}, active_div_q[0]};
    // The divisor that governs the period starting at the next wrap.
    assign next_div = pending_q ? pend_div_q : active_div_q;

    always_comb begin
        cnt_d        = cnt_q;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pending_d    = pending_q;
        clock_out_d  = clock_out_q;
        tick_d       = 1'b0;

        if (enable_i) begin
            if (wrap) begin
                // cnt becomes 0, which is always < H since H >= 1.
                cnt_d        = '0;
                active_div_d = next_div;
                clock_out_d  = 1'b1;
                tick_d       = 1'b1;
            end else begin
                cnt_d        = cnt_inc;
                clock_out_d  = (cnt_inc < half);
            end
        end

        // A load on the applying wrap edge re-arms pending with the new value;
        // the old pending value was already consumed through next_div above.
        if (load_i) begin
            pend_div_d = (div_value_i < MIN_DIV) ? MIN_DIV : div_value_i;
            pending_d  = 1'b1;
        end else if (enable_i && wrap && pending_q) begin
            pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q        <= RST_CNT;
            active_div_q <= RST_DIV;
            pend_div_q   <= RST_DIV;
            pending_q    <= 1'b0;
            clock_out_q  <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pending_q    <= pending_d;
            clock_out_q  <= clock_out_d;
            tick_q       <= tick_d;
        end
    end

    assign clock_out_o = clock_out_q;
    assign tick_o      = tick_q;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_clock_divider_n.sv
// Self-checking bench for clock_divider_n. The reference model tracks the
// position within the current period and the governing divisor as plain
// integers; expected outputs follow from "high while position < ceil(N/2)"
// and "tick on position 0".
module tb_clock_divider_n;

    localparam int WIDTH = 8;
    localparam int RDIV  = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             ld;
    logic [WIDTH-1:0] dv;
    logic             clk_out;
    logic             tick;
    logic             pending;

    int vectors;
    int miscompares;

    // reference model state
    int mN;     // divisor governing the current period
    int mph;    // position within the period, 0 .. mN-1
    int mpv;    // pending divisor value
    bit mpend;  // pending flag

    clock_divider_n #(.WIDTH(WIDTH), .RESET_DIV(RDIV)) dut (
        .clock_i     (clk),
        .reset_i     (rst_n),
        .enable_i    (en),
        .load_i      (ld),
        .div_value_i (dv),
        .clock_out_o (clk_out),
        .tick_o      (tick),
        .pending_o   (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b (N=%0d pos=%0d t=%0t)",
                   tag, obs, exp, mN, mph, $time);
        end
    endtask

    task automatic model_reset();
        mN    = RDIV;
        mph   = RDIV - 1;
        mpv   = RDIV;
        mpend = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then check all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (en) begin
                if (mph == mN - 1) begin
                    mph = 0;
                    if (mpend) begin
                        mN    = mpv;
                        mpend = 1'b0;
                    end
                end else begin
                    mph++;
                end
            end
            if (ld) begin
                mpv   = (int'(dv) < 2) ? 2 : int'(dv);
                mpend = 1'b1;
            end
        end
        #1;
        check("clock_out", clk_out, logic'(mph < (mN + 1) / 2));
        check("tick", tick, logic'(rst_n && en && mph == 0));
        check("pending", pending, logic'(mpend));
        ld = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_div(input int v);
        dv = WIDTH'(v);
        ld = 1'b1;
        step();
    endtask

    // Step until the model reports the given position (bounded).
    task automatic run_to_pos(input int pos, input string tag);
        int guard;
        guard = 0;
        while (mph != pos && guard < 600) begin
            step();
            guard++;
        end
        vectors++;
        if (mph != pos) begin
            miscompares++;
            $error("FAIL %s: position %0d not reached, observed %0d", tag, pos, mph);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        ld    = 1'b0;
        dv    = '0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_clock_out", clk_out, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_pending", pending, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // default divide-by-8, first edge is high + tick
        step();
        check("first_edge_tick", tick, 1'b1);
        check("first_edge_high", clk_out, 1'b1);
        run(23);

        // odd divisor loaded mid-period
        run(2);
        load_div(5);
        run(20);

        // clamp: 0 behaves as 2
        load_div(0);
        run(12);

        // extreme divisor 255
        load_div(255);
        run(2 + 255 * 2);

        // two loads within one period: only the last applies
        load_div(6);
        run(3);
        load_div(3);
        run(300);

        // load exactly on a wrap edge with nothing pending
        run_to_pos(2, "reach_wrap");   // N is 3, position 2 precedes the wrap
        load_div(4);
        check("wrap_load_pending", pending, 1'b1);
        run(3);
        check("wrap_load_applied_pending", pending, 1'b0);
        run(12);

        // enable gating frozen at position 2
        load_div(9);
        run(12);
        run_to_pos(2, "reach_pos2");
        en = 1'b0;
        run(7);
        en = 1'b1;
        run(20);

        // async reset between edges with a pending load
        load_div(3);
        check("pre_reset_pending", pending, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_clock_out", clk_out, 1'b0);
        check("async_rst_tick", tick, 1'b0);
        check("async_rst_pending", pending, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(20);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) begin
                ld = 1'b1;
                dv = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255))
                                                 : WIDTH'($urandom_range(0, 12));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
